// File: rtl/beep_pattern_gen.sv
// Beep pattern generator: turns a start strobe into N ON/OFF beeps on `level`,
// with registered rise/fall strobes aligned to each level transition.
module beep_pattern_gen #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 25_000_000,
  parameter int CNT_W      = 25
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] beep_count,
  output logic       level,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       busy,
  output logic       done
);

  // start and stop are single-cycle strobes sampled at posedge clk; there is no
  // ready: a start is accepted only in IDLE with stop low and beep_count != 0.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [3:0]       remaining, remaining_nxt;
  logic             level_nxt, rise_nxt, fall_nxt, busy_nxt, done_nxt;
  logic             accept, on_last, off_last;

  assign accept   = (state == S_IDLE) && start && !stop && (beep_count != 4'd0);
  assign on_last  = (state == S_ON)  && (timer == CNT_W'(ON_CYCLES - 1));
  assign off_last = (state == S_OFF) && (timer == CNT_W'(OFF_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state      <= S_IDLE;
      timer      <= '0;
      remaining  <= 4'd0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      remaining  <= remaining_nxt;
      level      <= level_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_ON;
      S_ON: begin
        if (stop)         state_nxt = S_IDLE;
        else if (on_last) state_nxt = (remaining == 4'd1) ? S_IDLE : S_OFF;
      end
      S_OFF: begin
        if (stop)          state_nxt = S_IDLE;
        else if (off_last) state_nxt = S_ON;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are the registered image of the next state, so every strobe lines
  // up with the level edge it describes.
  always_comb begin
    timer_nxt     = timer + 1'b1;
    remaining_nxt = remaining;
    if ((state_nxt != state) || (state_nxt == S_IDLE)) timer_nxt = '0;

    if (accept)                          remaining_nxt = beep_count;
    else if (stop && (state != S_IDLE))  remaining_nxt = 4'd0;
    else if (on_last)                    remaining_nxt = remaining - 4'd1;

    level_nxt = (state_nxt == S_ON);
    busy_nxt  = (state_nxt != S_IDLE);
    rise_nxt  = (state_nxt == S_ON) && (state != S_ON);
    fall_nxt  = (state == S_ON) && (state_nxt != S_ON);
    done_nxt  = on_last && !stop && (remaining == 4'd1);
  end

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Bench for beep_pattern_gen: an arithmetic waveform model (start time, beep
// count, abort) checked every cycle, plus literal waveform checks.
module tb_beep_pattern_gen;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int P   = ON + OFF;

  logic       clk = 1'b0;
  logic       reset_p, start, stop;
  logic [3:0] beep_count;
  logic       level, rise_pulse, fall_pulse, busy, done;

  int tests_run = 0;
  int tests_failed = 0;

  // model state
  int cyc = 0;
  bit act = 1'b0;
  int t0 = 0;
  int n = 0;
  bit prev_lvl = 1'b0;
  bit cur_lvl = 1'b0, cur_busy = 1'b0, cur_rise = 1'b0, cur_fall = 1'b0, cur_done = 1'b0;

  // DUT activity counters used by the literal checks
  int cnt_rise, cnt_fall, cnt_done, cnt_high;

  beep_pattern_gen #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(4)) dut (
    .clk(clk), .reset_p(reset_p), .start(start), .stop(stop),
    .beep_count(beep_count), .level(level), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act_v, input int exp_v);
    tests_run++;
    if (act_v !== exp_v) begin
      tests_failed++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act_v, exp_v);
    end
  endtask

  // Expected outputs for cycle `cyc` from the beep schedule: k counts cycles
  // since the first ON cycle; beeps occupy phase 0..ON-1 of each period P.
  function automatic void model_eval();
    int k;
    k = cyc - t0 - 1;
    cur_lvl  = act && (k >= 0) && (k / P < n) && (k % P < ON);
    cur_busy = act && (k >= 0) && (k < n * P - OFF);
    cur_done = act && (k == n * P - OFF);
    cur_rise = cur_lvl && !prev_lvl;
    cur_fall = !cur_lvl && prev_lvl;
  endfunction

  task automatic clear_counts();
    cnt_rise = 0; cnt_fall = 0; cnt_done = 0; cnt_high = 0;
  endtask

  task automatic step(input logic s, input logic sp, input logic [3:0] bc, input logic rst);
    start = s; stop = sp; beep_count = bc; reset_p = rst;
    if (rst) begin
      act = 1'b0;
      prev_lvl = 1'b0;
    end else begin
      if (cur_busy && sp) act = 1'b0;
      else if (!cur_busy && s && !sp && bc != 4'd0) begin
        act = 1'b1; t0 = cyc; n = int'(bc);
      end
      prev_lvl = cur_lvl;
    end
    @(posedge clk); #1;
    cyc++;
    model_eval();
    chk("level", level, cur_lvl);
    chk("rise_pulse", rise_pulse, cur_rise);
    chk("fall_pulse", fall_pulse, cur_fall);
    chk("busy", busy, cur_busy);
    chk("done", done, cur_done);
    cnt_rise += rise_pulse; cnt_fall += fall_pulse;
    cnt_done += done;       cnt_high += level;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  logic [10:0] lv_v, rs_v, fl_v, dn_v, bz_v;

  initial begin
    reset_p = 1'b1; start = 1'b0; stop = 1'b0; beep_count = 4'd0;

    // reset state
    step(1'b0, 1'b0, 4'd0, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("reset_level", level, 0);
    chk("reset_busy", busy, 0);
    idle(3);

    // normal pattern, count 2: step index == cycle whose inputs it drives
    lv_v = '0; rs_v = '0; fl_v = '0; dn_v = '0; bz_v = '0;
    lv_v[0] = level;
    for (int i = 1; i <= 10; i++) begin
      if (i == 1) step(1'b1, 1'b0, 4'd2, 1'b0);
      else        idle(1);
      lv_v[i] = level; rs_v[i] = rise_pulse; fl_v[i] = fall_pulse;
      dn_v[i] = done;  bz_v[i] = busy;
    end
    chk("normal_level_wave", int'(lv_v), 11'h1CE);
    chk("normal_rise_wave", int'(rs_v), 11'h042);
    chk("normal_fall_wave", int'(fl_v), 11'h210);
    chk("normal_done_wave", int'(dn_v), 11'h200);
    chk("normal_busy_wave", int'(bz_v), 11'h1FE);
    idle(2);

    // zero-count start is ignored
    clear_counts();
    step(1'b1, 1'b0, 4'd0, 1'b0);
    idle(20);
    chk("zero_start_high_cycles", cnt_high, 0);
    chk("zero_start_busy", busy, 0);

    // start while busy leaves the latched count alone
    clear_counts();
    step(1'b1, 1'b0, 4'd3, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 4'd7, 1'b0);
    idle(20);
    chk("busy_start_rises", cnt_rise, 3);
    chk("busy_start_dones", cnt_done, 1);

    // abort during the second ON phase (cycles 6-8), stop at cycle 7
    clear_counts();
    step(1'b1, 1'b0, 4'd4, 1'b0);
    idle(6);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    chk("abort_on_fall", fall_pulse, 1);
    chk("abort_on_busy", busy, 0);
    idle(10);
    chk("abort_on_dones", cnt_done, 0);
    chk("abort_on_falls", cnt_fall, 2);

    // abort during OFF (cycles 4-5), stop at cycle 4
    clear_counts();
    step(1'b1, 1'b0, 4'd3, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    chk("abort_off_fall", fall_pulse, 0);
    idle(8);
    chk("abort_off_falls", cnt_fall, 1);
    chk("abort_off_dones", cnt_done, 0);

    // start and stop together in IDLE
    clear_counts();
    step(1'b1, 1'b1, 4'd5, 1'b0);
    idle(5);
    chk("start_stop_high", cnt_high, 0);

    // stop on the final ON cycle (count 1, ON cycles 1-3)
    clear_counts();
    step(1'b1, 1'b0, 4'd1, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 4'd0, 1'b0);
    chk("last_on_stop_fall", fall_pulse, 1);
    chk("last_on_stop_done", done, 0);
    idle(5);
    chk("last_on_stop_dones", cnt_done, 0);

    // back-to-back: second start on the done cycle (cycle 4)
    lv_v = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || i == 4) step(1'b1, 1'b0, 4'd1, 1'b0);
      else                  idle(1);
      lv_v[i+1] = level;
    end
    chk("b2b_level_wave", int'(lv_v), 11'h0EE);
    idle(3);

    // reset mid-pattern
    clear_counts();
    step(1'b1, 1'b0, 4'd5, 1'b0);
    idle(4);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("midreset_busy", busy, 0);
    chk("midreset_fall", fall_pulse, 0);
    idle(12);
    chk("midreset_dones", cnt_done, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic s, sp, rst;
      logic [3:0] bc;
      s   = ($urandom_range(0, 7) == 0);
      sp  = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 199) == 0);
      bc  = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
      step(s, sp, bc, rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
